// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and issues req/ack reads to instruction memory.
// It presents one fetched instruction to the IF/ID register, and honours stall and redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] PC_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD,
    DROP
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] pend_addr_q;
  logic [31:0] pend_data_q;

  logic consume;
  logic slot_free;
  logic accept;

  always_comb begin
    consume     = valid_o & ~stall_i;
    slot_free   = ~valid_o | consume;
    imem_req_o  = ((state_q == IDLE) & slot_free & ~redirect_i) |
                  (state_q == BUSY) | (state_q == DROP);
    imem_addr_o = (state_q == IDLE) ? pc_q : addr_q;
    accept      = imem_req_o & imem_ack_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= '0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      PC_o        <= '0;
      inst_o      <= '0;
      valid_o     <= 1'b0;
    end else if (redirect_i) begin
      // Any in-flight or parked data is stale; an unacked request is still
      // driven to completion (DROP) so the memory handshake stays intact.
      pc_q    <= redirect_pc_i & 32'hFFFF_FFFC;
      valid_o <= 1'b0;
      case (state_q)
        BUSY:    state_q <= accept ? IDLE : DROP;
        DROP:    state_q <= accept ? IDLE : DROP;
        default: state_q <= IDLE;
      endcase
    end else begin
      if (consume) begin
        valid_o <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (imem_req_o) begin
            addr_q <= pc_q;
            if (accept) begin
              PC_o    <= pc_q;
              inst_o  <= imem_data_i;
              valid_o <= 1'b1;
              pc_q    <= pc_q + STEP;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (accept) begin
            if (slot_free) begin
              PC_o    <= addr_q;
              inst_o  <= imem_data_i;
              valid_o <= 1'b1;
              pc_q    <= addr_q + STEP;
              state_q <= IDLE;
            end else begin
              pend_addr_q <= addr_q;
              pend_data_q <= imem_data_i;
              pc_q        <= addr_q + STEP;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (consume) begin
            PC_o    <= pend_addr_q;
            inst_o  <= pend_data_q;
            valid_o <= 1'b1;
            state_q <= IDLE;
          end
        end
        DROP: begin
          if (accept) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
